// File: rtl/gpu_pixel_arbiter.sv
// Fair two-requester pixel arbiter feeding one frame-buffer write port; accept->mem_wr_o latency 1 cycle.
// Backpressure: ready only while idle or on the mem_ack_i cycle, so back-to-back writes carry no bubble.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_arbiter #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int ADDR_BITS = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       line_valid_i,
  input  logic [`WIDTH_BITS-1:0]     line_x_i,
  input  logic [`HEIGHT_BITS-1:0]    line_y_i,
  input  logic [3*`CHANNEL_BITS-1:0] line_rgb_i,
  output logic                       line_ready_o,
  input  logic                       fill_valid_i,
  input  logic [`WIDTH_BITS-1:0]     fill_x_i,
  input  logic [`HEIGHT_BITS-1:0]    fill_y_i,
  input  logic [3*`CHANNEL_BITS-1:0] fill_rgb_i,
  output logic                       fill_ready_o,
  output logic                       mem_wr_o,
  output logic [ADDR_BITS-1:0]       mem_addr_o,
  output logic [3*`CHANNEL_BITS-1:0] mem_data_o,
  input  logic                       mem_ack_i,
  output logic                       idle_o,
  output logic                       drop_o,
  input  logic                       clear_cnt_i,
  output logic [15:0]                pix_cnt_o
);
  localparam int PW = 3*`CHANNEL_BITS;
  localparam logic [31:0] W32 = SCREEN_W;
  localparam logic [31:0] H32 = SCREEN_H;

  typedef enum logic {IDLE, WRITE} state_e;
  typedef enum logic {GNT_LINE, GNT_FILL} gnt_e;
  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [PW-1:0]        data;
  } wr_t;

  state_e state_q, state_d;
  gnt_e   last_grant_q, last_grant_d;
  wr_t    wr_q, wr_d;
  logic   drop_q, drop_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;

  logic                    window, pick_line, accept, in_range, write_done;
  logic [`WIDTH_BITS-1:0]  sel_x;
  logic [`HEIGHT_BITS-1:0] sel_y;
  logic [PW-1:0]           sel_rgb;
  logic [ADDR_BITS-1:0]    sel_addr;

  always_comb begin
    window       = !rst && ((state_q == IDLE) || mem_ack_i);
    pick_line    = line_valid_i && (!fill_valid_i || (last_grant_q == GNT_FILL));
    line_ready_o = window && pick_line;
    fill_ready_o = window && fill_valid_i && !pick_line;
    accept       = line_ready_o || fill_ready_o;
    write_done   = (state_q == WRITE) && mem_ack_i;

    sel_x   = pick_line ? line_x_i   : fill_x_i;
    sel_y   = pick_line ? line_y_i   : fill_y_i;
    sel_rgb = pick_line ? line_rgb_i : fill_rgb_i;
    // Modular product: the low ADDR_BITS equal those of the full-width y*W+x.
    sel_addr = ADDR_BITS'(sel_y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(sel_x);
    in_range = (32'(sel_x) < W32) && (32'(sel_y) < H32);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    drop_d       = 1'b0;
    pix_cnt_d    = pix_cnt_q;

    if (write_done) state_d = IDLE;
    if (accept) begin
      wr_d.addr    = sel_addr;
      wr_d.data    = sel_rgb;
      last_grant_d = pick_line ? GNT_LINE : GNT_FILL;
      if (in_range) state_d = WRITE;
      else          drop_d  = 1'b1;
    end

    // Clear wins over a same-cycle completion.
    if (clear_cnt_i)                              pix_cnt_d = '0;
    else if (write_done && pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FILL;
      wr_q         <= '0;
      drop_q       <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      drop_q       <= drop_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  assign mem_wr_o   = (state_q == WRITE);
  assign mem_addr_o = wr_q.addr;
  assign mem_data_o = wr_q.data;
  assign drop_o     = drop_q;
  assign pix_cnt_o  = pix_cnt_q;
  assign idle_o     = (state_q == IDLE) && !line_valid_i && !fill_valid_i && !drop_q;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Randomized and directed bench for gpu_pixel_arbiter against a transaction-level reference model.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_pixel_arbiter;
  localparam int WB = `WIDTH_BITS;
  localparam int HB = `HEIGHT_BITS;
  localparam int PW = 3*`CHANNEL_BITS;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int AB = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_valid_i, fill_valid_i, line_ready_o, fill_ready_o;
  logic [WB-1:0] line_x_i, fill_x_i;
  logic [HB-1:0] line_y_i, fill_y_i;
  logic [PW-1:0] line_rgb_i, fill_rgb_i, mem_data_o;
  logic          mem_wr_o, mem_ack_i, idle_o, drop_o, clear_cnt_i;
  logic [AB-1:0] mem_addr_o;
  logic [15:0]   pix_cnt_o;

  gpu_pixel_arbiter #(.SCREEN_W(SW), .SCREEN_H(SH), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .line_valid_i(line_valid_i), .line_x_i(line_x_i), .line_y_i(line_y_i),
    .line_rgb_i(line_rgb_i), .line_ready_o(line_ready_o),
    .fill_valid_i(fill_valid_i), .fill_x_i(fill_x_i), .fill_y_i(fill_y_i),
    .fill_rgb_i(fill_rgb_i), .fill_ready_o(fill_ready_o),
    .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .idle_o(idle_o), .drop_o(drop_o),
    .clear_cnt_i(clear_cnt_i), .pix_cnt_o(pix_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one outstanding write, a saturating count, a fairness bit.
  bit m_busy, m_drop, m_last_line;
  int m_addr, m_data, m_cnt;
  bit g_line, g_any;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_line(input bit v, input int x, input int y, input int rgb);
    line_valid_i = v; line_x_i = WB'(x); line_y_i = HB'(y); line_rgb_i = PW'(rgb);
  endtask

  task automatic set_fill(input bit v, input int x, input int y, input int rgb);
    fill_valid_i = v; fill_x_i = WB'(x); fill_y_i = HB'(y); fill_rgb_i = PW'(rgb);
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    bit win, gl, gf, inr;
    int x, y, rgb;
    @(negedge clk);
    win = !m_busy || (mem_ack_i === 1'b1);
    gl = 1'b0; gf = 1'b0;
    if (win) begin
      if (line_valid_i && fill_valid_i) begin
        gl = !m_last_line; gf = m_last_line;
      end else begin
        gl = line_valid_i; gf = fill_valid_i;
      end
    end
    chk("line_ready", 32'(line_ready_o), 32'(gl));
    chk("fill_ready", 32'(fill_ready_o), 32'(gf));
    chk("mem_wr", 32'(mem_wr_o), 32'(m_busy));
    if (m_busy) begin
      chk("mem_addr", 32'(mem_addr_o), m_addr);
      chk("mem_data", 32'(mem_data_o), m_data);
    end
    chk("drop", 32'(drop_o), 32'(m_drop));
    chk("idle", 32'(idle_o), 32'(!m_busy && !line_valid_i && !fill_valid_i && !m_drop));
    chk("pix_cnt", 32'(pix_cnt_o), m_cnt);

    if (clear_cnt_i) m_cnt = 0;
    else if (m_busy && mem_ack_i && m_cnt < 65535) m_cnt++;
    if (gl || gf) begin
      x   = gl ? int'(line_x_i)   : int'(fill_x_i);
      y   = gl ? int'(line_y_i)   : int'(fill_y_i);
      rgb = gl ? int'(line_rgb_i) : int'(fill_rgb_i);
      inr = (x < SW) && (y < SH);
      m_addr = (y * SW + x) % (1 << AB);
      m_data = rgb;
      m_last_line = gl;
      m_busy = inr;
      m_drop = !inr;
    end else begin
      m_busy = m_busy && !mem_ack_i;
      m_drop = 1'b0;
    end
    g_line = gl;
    g_any  = gl || gf;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_wr", 32'(mem_wr_o), 0);
    chk("rst_addr", 32'(mem_addr_o), 0);
    chk("rst_data", 32'(mem_data_o), 0);
    chk("rst_drop", 32'(drop_o), 0);
    chk("rst_cnt", 32'(pix_cnt_o), 0);
    chk("rst_line_ready", 32'(line_ready_o), 0);
    chk("rst_fill_ready", 32'(fill_ready_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_busy = 1'b0; m_drop = 1'b0; m_cnt = 0; m_last_line = 1'b0;
  endtask

  initial begin
    bit gseq[$];
    int lrem, frem;

    rst = 1'b1;
    set_line(0, 0, 0, 0); set_fill(0, 0, 0, 0);
    mem_ack_i = 1'b0; clear_cnt_i = 1'b0;
    do_reset();

    // Single line pixel, ack on the third write cycle.
    set_line(1, 5, 2, 24'hFF0000);
    step();
    chk("t1_grant_line", 32'(g_line), 1);
    set_line(0, 0, 0, 0);
    chk("t1_wr", 32'(mem_wr_o), 1);
    chk("t1_addr", 32'(mem_addr_o), 1285);
    chk("t1_data", 32'(mem_data_o), 32'h00FF0000);
    step();
    step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("t1_cnt", 32'(pix_cnt_o), 1);
    chk("t1_idle", 32'(idle_o), 1);

    // Contention: four pixels per requester, ack every cycle.
    do_reset();
    lrem = 4; frem = 4;
    mem_ack_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_line(lrem > 0, 10 + lrem, 20, 24'h00AA00 + lrem);
      set_fill(frem > 0, 30 + frem, 40, 24'h0000BB + frem);
      if (lrem == 0 && frem == 0 && !m_busy) break;
      step();
      if (g_any) begin
        gseq.push_back(g_line);
        if (g_line) lrem--; else frem--;
      end
    end
    set_line(0, 0, 0, 0); set_fill(0, 0, 0, 0);
    mem_ack_i = 1'b0;
    chk("t2_grants", 32'(gseq.size()), 8);
    foreach (gseq[i]) chk($sformatf("t2_grant%0d", i), 32'(gseq[i]), 32'((i % 2) == 0));
    chk("t2_cnt", 32'(pix_cnt_o), 8);

    // Out-of-range fill pixel is accepted and dropped.
    clear_cnt_i = 1'b1;
    step();
    clear_cnt_i = 1'b0;
    set_fill(1, 640, 0, 24'h123456);
    step();
    set_fill(0, 0, 0, 0);
    chk("t3_drop", 32'(drop_o), 1);
    chk("t3_no_wr", 32'(mem_wr_o), 0);
    step();
    chk("t3_drop_end", 32'(drop_o), 0);
    chk("t3_cnt", 32'(pix_cnt_o), 0);

    // Last on-screen pixel.
    set_line(1, 639, 479, 24'h0F0F0F);
    step();
    set_line(0, 0, 0, 0);
    chk("t4_addr", 32'(mem_addr_o), 307199);
    chk("t4_wr", 32'(mem_wr_o), 1);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("t4_cnt", 32'(pix_cnt_o), 1);

    // Reset in the middle of an unacknowledged write.
    set_line(1, 10, 10, 24'hABCDEF);
    step();
    set_line(0, 0, 0, 0);
    step();
    step();
    do_reset();
    set_line(1, 1, 1, 24'h010203);
    step();
    chk("t5_first_accept", 32'(g_line), 1);
    set_line(0, 0, 0, 0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      set_line($urandom_range(0, 1),
               ($urandom_range(0, 9) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639),
               ($urandom_range(0, 9) == 0) ? $urandom_range(480, 511)  : $urandom_range(0, 479),
               $urandom);
      set_fill($urandom_range(0, 1),
               ($urandom_range(0, 9) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639),
               ($urandom_range(0, 9) == 0) ? $urandom_range(480, 511)  : $urandom_range(0, 479),
               $urandom);
      mem_ack_i   = ($urandom_range(0, 2) != 0);
      clear_cnt_i = ($urandom_range(0, 63) == 0);
      step();
    end
    set_line(0, 0, 0, 0); set_fill(0, 0, 0, 0);
    clear_cnt_i = 1'b0;
    mem_ack_i = 1'b1;
    step();
    step();

    // Counter saturation and clear priority.
    clear_cnt_i = 1'b1;
    step();
    clear_cnt_i = 1'b0;
    set_line(1, 3, 3, 24'h777777);
    mem_ack_i = 1'b1;
    for (int k = 0; k < 70000 && m_cnt < 65535; k++) step();
    chk("t6_reached_max", 32'(pix_cnt_o), 32'hFFFF);
    step();
    chk("t6_saturated", 32'(pix_cnt_o), 32'hFFFF);
    clear_cnt_i = 1'b1;
    step();
    clear_cnt_i = 1'b0;
    chk("t6_clear_wins", 32'(pix_cnt_o), 0);
    set_line(0, 0, 0, 0);
    step();
    mem_ack_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
